// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, opcode encodings and the packed
// result-buffer entry that carries a result with its opcode and status flags.
package alu_pkg;

   localparam int unsigned ALU_DATA_W = 6;
   localparam int unsigned ALU_OP_W   = 3;

   localparam logic [ALU_OP_W-1:0] OP_0 = 3'b000;
   localparam logic [ALU_OP_W-1:0] OP_1 = 3'b001;
   localparam logic [ALU_OP_W-1:0] OP_2 = 3'b010;
   localparam logic [ALU_OP_W-1:0] OP_3 = 3'b011;
   localparam logic [ALU_OP_W-1:0] OP_4 = 3'b100;
   localparam logic [ALU_OP_W-1:0] OP_5 = 3'b101;
   localparam logic [ALU_OP_W-1:0] OP_6 = 3'b110;
   localparam logic [ALU_OP_W-1:0] OP_7 = 3'b111;

   // One buffered result; flags are captured together with the result.
   typedef struct packed {
      logic [ALU_OP_W-1:0]   opcode;
      logic [ALU_DATA_W-1:0] result;
      logic                  zero;
      logic                  neg;
      logic                  parity;
   } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag generator: zero, sign (MSB) and XOR parity of a
// result word. Shared between the ALU top and the result buffer push side.
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int unsigned W = ALU_DATA_W
) (
   input  logic [W-1:0] result,
   output logic         zero,
   output logic         neg,
   output logic         parity
);

   // Flags are pure functions of the result word.
   always_comb begin
      zero   = (result == '0);
      neg    = result[W-1];
      parity = ^result;
   end

endmodule

// File: rtl/alu_result_buffer.sv
// ALU result buffer: first-word-fall-through FIFO between the ALU output
// multiplexer and the consumer, with valid/ready handshakes on both sides.
// Status flags are computed when a result is pushed and stored with it.
// DATA_W/OP_W must match ALU_DATA_W/ALU_OP_W since entries use alu_entry_t.
// Optional macro ALU_BUF_STATS_EN adds push_count and peak_level outputs.
module alu_result_buffer
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = ALU_DATA_W,
   parameter int unsigned OP_W   = ALU_OP_W,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_result,
   input  logic [OP_W-1:0]         in_opcode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_result,
   output logic [OP_W-1:0]         out_opcode,
   output logic                    out_zero,
   output logic                    out_neg,
`ifdef ALU_BUF_STATS_EN
   output logic [7:0]              push_count,
   output logic [$clog2(DEPTH):0]  peak_level,
`endif
   output logic                    out_parity
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);

   alu_entry_t        mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;

   logic              push;
   logic              pop;
   logic              in_zero;
   logic              in_neg;
   logic              in_parity;
   alu_entry_t        wr_entry;
   alu_entry_t        head;

   alu_flag_gen #(
      .W (DATA_W)
   ) u_flags (
      .result (in_result),
      .zero   (in_zero),
      .neg    (in_neg),
      .parity (in_parity)
   );

   // Handshake qualification; in_ready depends on registered count only.
   always_comb begin
      in_ready  = (count != FULL_LEVEL);
      out_valid = (count != '0);
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
   end

   // Assemble the entry written on push, flags taken from the live input.
   always_comb begin
      wr_entry        = '0;
      wr_entry.opcode = in_opcode;
      wr_entry.result = in_result;
      wr_entry.zero   = in_zero;
      wr_entry.neg    = in_neg;
      wr_entry.parity = in_parity;
   end

   // Occupancy update; simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // Entry storage, cleared on reset and written at wr_ptr on push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_next;
      end
   end

   // Head entry presented combinationally; all fields forced to 0 when empty.
   always_comb begin
      head       = mem[rd_ptr];
      out_result = '0;
      out_opcode = '0;
      out_zero   = 1'b0;
      out_neg    = 1'b0;
      out_parity = 1'b0;
      if (out_valid) begin
         out_result = head.result;
         out_opcode = head.opcode;
         out_zero   = head.zero;
         out_neg    = head.neg;
         out_parity = head.parity;
      end
   end

`ifdef ALU_BUF_STATS_EN
   // Accepted-push counter (wraps) and high-water mark of occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         push_count <= '0;
         peak_level <= '0;
      end else begin
         if (push) begin
            push_count <= push_count + 8'd1;
         end
         if (count_next > peak_level) begin
            peak_level <= count_next;
         end
      end
   end
`endif

endmodule
